// File: rtl/sm3_msg_pack.sv
// Byte-stream to word packer feeding the SM3 core message port (big-endian, MSB-aligned masks).
// Optional per-message byte counter on msg_byte_cnt when SM3_PACK_LEN_CNT_EN is defined.
module sm3_msg_pack #(
    parameter int unsigned DW = 32,
    parameter int unsigned NB = DW / 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    byte_in_d,
    input  logic          byte_in_vld,
    input  logic          byte_in_lst,
    output logic          byte_in_rdy,
    output logic [DW-1:0] msg_inpt_d,
    output logic [NB-1:0] msg_inpt_vld_byte,
    output logic          msg_inpt_vld,
    output logic          msg_inpt_lst,
    input  logic          msg_inpt_rdy,
    output logic          busy
`ifdef SM3_PACK_LEN_CNT_EN
    ,
    output logic [60:0]   msg_byte_cnt
`endif
);

    localparam int unsigned CW = $clog2(NB);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_FULL
    } state_t;

    state_t          state_q, state_n;
    logic [CW-1:0]   cnt_q, cnt_n;
    logic [DW-1:0]   acc_q, acc_n;
    logic [NB-1:0]   full_vb_q, full_vb_n;
    logic            full_lst_q, full_lst_n;

    logic [DW-1:0]   out_d_n;
    logic [NB-1:0]   out_vb_n;
    logic            out_vld_n;
    logic            out_lst_n;
    logic            busy_n;

    logic            byte_acc_c;
    logic            fire_c;
    logic            out_free_c;
    logic            word_done_c;
    logic [DW-1:0]   word_c;
    logic [NB-1:0]   vb_c;

    assign byte_in_rdy = (state_q != S_FULL);
    assign byte_acc_c  = byte_in_vld && byte_in_rdy;
    assign fire_c      = msg_inpt_vld && msg_inpt_rdy;
    assign out_free_c  = !msg_inpt_vld || msg_inpt_rdy;
    assign word_done_c = (cnt_q == CW'(NB - 1)) || byte_in_lst;

    // Accumulator with the incoming byte merged at slot cnt_q, and the mask for cnt_q+1 bytes.
    always_comb begin
        word_c = acc_q;
        vb_c   = '0;
        for (int i = 0; i < NB; i++) begin
            if (CW'(i) == cnt_q) begin
                word_c[DW-1-8*i -: 8] = byte_in_d;
            end
            vb_c[NB-1-i] = (CW'(i) <= cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= S_IDLE;
            cnt_q             <= '0;
            acc_q             <= '0;
            full_vb_q         <= '0;
            full_lst_q        <= 1'b0;
            msg_inpt_d        <= '0;
            msg_inpt_vld_byte <= '0;
            msg_inpt_vld      <= 1'b0;
            msg_inpt_lst      <= 1'b0;
            busy              <= 1'b0;
        end else begin
            state_q           <= state_n;
            cnt_q             <= cnt_n;
            acc_q             <= acc_n;
            full_vb_q         <= full_vb_n;
            full_lst_q        <= full_lst_n;
            msg_inpt_d        <= out_d_n;
            msg_inpt_vld_byte <= out_vb_n;
            msg_inpt_vld      <= out_vld_n;
            msg_inpt_lst      <= out_lst_n;
            busy              <= busy_n;
        end
    end

    // Next-state: a completed word goes straight to the output register when it is free, else parks in FULL.
    always_comb begin
        state_n    = state_q;
        cnt_n      = cnt_q;
        acc_n      = acc_q;
        full_vb_n  = full_vb_q;
        full_lst_n = full_lst_q;
        out_d_n    = msg_inpt_d;
        out_vb_n   = msg_inpt_vld_byte;
        out_vld_n  = msg_inpt_vld;
        out_lst_n  = msg_inpt_lst;
        busy_n     = busy;

        if (fire_c) begin
            out_vld_n = 1'b0;
        end

        case (state_q)
            S_IDLE, S_ACC: begin
                if (byte_acc_c) begin
                    if (word_done_c) begin
                        cnt_n = '0;
                        if (out_free_c) begin
                            out_d_n   = word_c;
                            out_vb_n  = vb_c;
                            out_lst_n = byte_in_lst;
                            out_vld_n = 1'b1;
                            acc_n     = '0;
                            state_n   = S_IDLE;
                        end else begin
                            acc_n      = word_c;
                            full_vb_n  = vb_c;
                            full_lst_n = byte_in_lst;
                            state_n    = S_FULL;
                        end
                    end else begin
                        acc_n   = word_c;
                        cnt_n   = cnt_q + CW'(1);
                        state_n = S_ACC;
                    end
                end
            end
            S_FULL: begin
                if (out_free_c) begin
                    out_d_n    = acc_q;
                    out_vb_n   = full_vb_q;
                    out_lst_n  = full_lst_q;
                    out_vld_n  = 1'b1;
                    acc_n      = '0;
                    full_vb_n  = '0;
                    full_lst_n = 1'b0;
                    state_n    = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Bytes still held in the accumulator belong to the next message, so busy survives the lst beat.
        if (byte_acc_c) begin
            busy_n = 1'b1;
        end else if (fire_c && msg_inpt_lst) begin
            busy_n = (state_q != S_IDLE);
        end
    end

`ifdef SM3_PACK_LEN_CNT_EN
    logic in_msg_q;

    // Per-message byte count; restarts at 1 on the first byte after a lst byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_byte_cnt <= '0;
            in_msg_q     <= 1'b0;
        end else if (byte_acc_c) begin
            msg_byte_cnt <= in_msg_q ? (msg_byte_cnt + 61'(1)) : 61'(1);
            in_msg_q     <= !byte_in_lst;
        end
    end
`endif

endmodule
